mem_access_controller: RTL and testbench



---
 rtl/mem_access_controller.sv | 138 +++++++++++++
 tb/tb_mem_access_controller.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_controller.sv
// Sequences a 32-bit MEM-stage access onto a 16-bit async SRAM as two half-word
// phases (low then high), stalling the pipeline through `ready` until done.
module mem_access_controller #(
    parameter int unsigned BASE_ADDR   = 1024,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned SRAM_ADDR_W = 18
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rd_en,
    input  logic                   wr_en,
    input  logic [31:0]            address,
    input  logic [31:0]            wdata,
    output logic [31:0]            rdata,
    output logic                   ready,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic [15:0]            sram_dq_out,
    output logic                   sram_dq_oe,
    input  logic [15:0]            sram_dq_in,
    output logic                   sram_we_n
);

    // state | meaning
    // IDLE  | waiting for rd_en/wr_en; ready follows the absence of a request
    // LOW   | half-word phase for data bits [15:0], W+1 cycles
    // HIGH  | half-word phase for data bits [31:16], W+1 cycles
    // DONE  | one cycle with ready = 1 while the pipeline advances
    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

    localparam logic [3:0] W = WAIT_CYCLES[3:0];

    state_t                 state_q, state_n;
    logic [3:0]             cnt_q, cnt_n;
    logic                   is_wr_q;
    logic [SRAM_ADDR_W-2:0] off_q;
    logic [15:0]            wdata_hi_q;

    logic                   req;
    logic                   latch;
    logic                   cap_lo, cap_hi;
    logic [31:0]            addr_diff;
    logic [SRAM_ADDR_W-2:0] off_in;
    logic [SRAM_ADDR_W-1:0] addr_n;
    logic [15:0]            dq_out_n;
    logic                   oe_n;
    logic                   we_n_n;
    logic                   unused_addr_bits;

    assign req       = rd_en | wr_en;
    assign addr_diff = address - BASE_ADDR;
    // Only the bits that survive truncation to the SRAM half-word address are kept.
    assign off_in    = addr_diff[SRAM_ADDR_W:2];
    assign unused_addr_bits = ^{addr_diff[31:SRAM_ADDR_W+1], addr_diff[1:0]};

    always_comb begin
        state_n  = state_q;
        cnt_n    = cnt_q;
        latch    = 1'b0;
        cap_lo   = 1'b0;
        cap_hi   = 1'b0;
        ready    = 1'b0;
        addr_n   = sram_addr;
        dq_out_n = sram_dq_out;
        oe_n     = sram_dq_oe;
        we_n_n   = sram_we_n;
        case (state_q)
            IDLE: begin
                ready = ~req;
                if (req) begin
                    state_n = LOW;
                    cnt_n   = 4'd0;
                    latch   = 1'b1;
                    addr_n  = {off_in, 1'b0};
                    if (wr_en) dq_out_n = wdata[15:0];
                    oe_n    = wr_en;
                    we_n_n  = ~wr_en;
                end
            end
            LOW, HIGH: begin
                if (cnt_q == W) begin
                    cnt_n = 4'd0;
                    if (state_q == LOW) begin
                        state_n = HIGH;
                        cap_lo  = ~is_wr_q;
                        addr_n  = {off_q, 1'b1};
                        if (is_wr_q) dq_out_n = wdata_hi_q;
                        oe_n    = is_wr_q;
                        we_n_n  = ~is_wr_q;
                    end else begin
                        state_n = DONE;
                        cap_hi  = ~is_wr_q;
                        oe_n    = 1'b0;
                        we_n_n  = 1'b1;
                    end
                end else begin
                    cnt_n  = cnt_q + 4'd1;
                    // Strobe rises one cycle before the phase ends so data holds past WE#.
                    we_n_n = ~(is_wr_q && (cnt_n < W));
                end
            end
            DONE: begin
                ready   = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            is_wr_q     <= 1'b0;
            off_q       <= '0;
            wdata_hi_q  <= 16'd0;
            rdata       <= 32'd0;
            sram_addr   <= '0;
            sram_dq_out <= 16'd0;
            sram_dq_oe  <= 1'b0;
            sram_we_n   <= 1'b1;
        end else begin
            state_q     <= state_n;
            cnt_q       <= cnt_n;
            sram_addr   <= addr_n;
            sram_dq_out <= dq_out_n;
            sram_dq_oe  <= oe_n;
            sram_we_n   <= we_n_n;
            if (latch) begin
                is_wr_q    <= wr_en;
                off_q      <= off_in;
                wdata_hi_q <= wdata[31:16];
            end
            if (cap_lo) rdata[15:0]  <= sram_dq_in;
            if (cap_hi) rdata[31:16] <= sram_dq_in;
        end
    end

endmodule

// File: tb/tb_mem_access_controller.sv
// Bench for mem_access_controller: SRAM model, table-driven accesses, corner
// sequences and randomized accesses against a word-level reference memory.
module tb_mem_access_controller;

    localparam int W    = 2;
    localparam int BASE = 1024;
    localparam int AW   = 18;
    localparam int MEMN = 1 << AW;

    logic          clk;
    logic          rst;
    logic          rd_en, wr_en;
    logic [31:0]   address, wdata;
    logic [31:0]   rdata;
    logic          ready;
    logic [AW-1:0] sram_addr;
    logic [15:0]   sram_dq_out;
    logic          sram_dq_oe;
    logic [15:0]   sram_dq_in;
    logic          sram_we_n;

    logic [15:0] sram_mem [0:MEMN-1];
    logic [15:0] ref_mem  [0:MEMN-1];
    logic [31:0] ref_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    mem_access_controller #(.BASE_ADDR(BASE), .WAIT_CYCLES(W), .SRAM_ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .address(address),
        .wdata(wdata), .rdata(rdata), .ready(ready), .sram_addr(sram_addr),
        .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe), .sram_dq_in(sram_dq_in),
        .sram_we_n(sram_we_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign sram_dq_in = sram_mem[sram_addr];
    always @(posedge clk)
        if (rst && !sram_we_n && sram_dq_oe) sram_mem[sram_addr] <= sram_dq_out;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [AW-1:0] lo_of(input logic [31:0] a);
        int unsigned word;
        word = (a - 32'(BASE)) / 4;
        return AW'((word * 2) % MEMN);
    endfunction

    function automatic void model_update(input logic wr, input logic [AW-1:0] lo, input logic [31:0] wd);
        if (wr) begin
            ref_mem[lo]      = wd[15:0];
            ref_mem[lo + 1]  = wd[31:16];
        end else begin
            ref_rdata = {ref_mem[lo + 1], ref_mem[lo]};
        end
    endfunction

    // One access from an idle controller; checks every in-flight cycle's SRAM signals.
    task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                             input logic [31:0] wd, input logic [AW-1:0] exp_lo,
                             input logic [31:0] exp_rd, input int drop_at);
        int k, low, ph, c;
        logic done;
        logic [AW-1:0] e_addr;
        logic e_we;
        logic [15:0] e_dq;
        k = 0; low = 0; done = 1'b0;
        @(negedge clk);
        rd_en = rd; wr_en = wr; address = addr; wdata = wd;
        #1;
        while (!done && k < 100) begin
            if (ready) begin
                done = 1'b1;
            end else begin
                low++;
                if (k >= 1) begin
                    ph     = (k <= W + 1) ? 0 : 1;
                    c      = (k - 1) % (W + 1);
                    e_addr = exp_lo + AW'(ph);
                    e_we   = !(wr && c < W);
                    e_dq   = ph ? wd[31:16] : wd[15:0];
                    check("sram_phase",
                          64'({sram_addr, sram_we_n, sram_dq_oe, wr ? sram_dq_out : 16'h0}),
                          64'({e_addr, e_we, wr, wr ? e_dq : 16'h0}));
                end
                if (drop_at != 0 && k == drop_at) begin
                    rd_en = 1'b0; wr_en = 1'b0;
                end
                @(negedge clk); #1;
                k++;
            end
        end
        if (!done) check("ready_timeout", 64'(0), 64'(1));
        check("ready_low_cycles", 64'(low), 64'(2 * W + 3));
        check("rdata_done", 64'(rdata), 64'(exp_rd));
        check("done_oe_we", 64'({sram_dq_oe, sram_we_n}), 64'(2'b01));
        rd_en = 1'b0; wr_en = 1'b0;
        model_update(wr, exp_lo, wd);
    endtask

    typedef struct {
        logic          rd;
        logic          wr;
        logic [31:0]   addr;
        logic [31:0]   wd;
        logic [AW-1:0] exp_lo;
        logic [31:0]   exp_rd;
    } vec_t;

    vec_t vecs [7];

    initial begin
        logic [15:0] pat, exp_pat;
        logic [31:0] a, wd;
        logic r, w;
        logic [AW-1:0] lo;
        int drop;

        vecs[0] = '{1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, 18'h00004, 32'h00000000};
        vecs[1] = '{1'b1, 1'b0, 32'd1032, 32'h0,        18'h00004, 32'hDEADBEEF};
        vecs[2] = '{1'b1, 1'b1, 32'd1024, 32'h12345678, 18'h00000, 32'hDEADBEEF};
        vecs[3] = '{1'b1, 1'b0, 32'd1024, 32'h0,        18'h00000, 32'h12345678};
        vecs[4] = '{1'b0, 1'b1, 32'd1020, 32'hCAFEF00D, 18'h3FFFE, 32'h12345678};
        vecs[5] = '{1'b1, 1'b0, 32'd1020, 32'h0,        18'h3FFFE, 32'hCAFEF00D};
        vecs[6] = '{1'b1, 1'b0, 32'd1035, 32'h0,        18'h00004, 32'hDEADBEEF};

        for (int i = 0; i < MEMN; i++) begin
            sram_mem[i] = 16'h0;
            ref_mem[i]  = 16'h0;
        end
        ref_rdata = 32'h0;
        rd_en = 1'b0; wr_en = 1'b0; address = 32'h0; wdata = 32'h0;
        rst = 1'b1;
        #1 rst = 1'b0;
        #3;
        check("reset_outputs",
              64'({rdata, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n, ready}),
              64'({32'h0, 18'h0, 16'h0, 1'b0, 1'b1, 1'b1}));
        @(negedge clk); @(negedge clk);
        rst = 1'b1;

        // Reset in LOW at cnt = 1 of a write: strobe released at once, high half never written.
        @(negedge clk);
        wr_en = 1'b1; address = BASE + 400; wdata = 32'hA5A55A5A;
        @(negedge clk); @(negedge clk); #1;
        check("prereset_we_low", 64'({sram_we_n, sram_dq_oe, ready}), 64'({1'b0, 1'b1, 1'b0}));
        rst = 1'b0; wr_en = 1'b0;
        #1;
        check("midwrite_reset",
              64'({sram_we_n, sram_dq_oe, ready, sram_addr}),
              64'({1'b1, 1'b0, 1'b1, 18'h0}));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk); #1;
        check("aborted_high_half", 64'(sram_mem[201]), 64'(16'h0));
        check("idle_after_reset", 64'({ready, sram_we_n}), 64'(2'b11));
        ref_mem[200] = 16'h5A5A;

        for (int i = 0; i < 7; i++)
            do_access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wd,
                      vecs[i].exp_lo, vecs[i].exp_rd, 0);

        // rd_en held across DONE: two back-to-back reads in 16 cycles.
        @(negedge clk);
        rd_en = 1'b1; address = 32'd1032;
        pat = '0; exp_pat = '0;
        for (int k = 0; k < 16; k++) begin
            #1;
            pat[k]     = ready;
            exp_pat[k] = (k == 2 * W + 3) || (k == 4 * W + 7);
            if (k == 2 * W + 5) check("second_access_addr", 64'(sram_addr), 64'(18'h4));
            @(negedge clk);
        end
        rd_en = 1'b0;
        #1;
        check("b2b_ready_pattern", 64'(pat), 64'(exp_pat));
        check("b2b_rdata", 64'(rdata), 64'(32'hDEADBEEF));
        check("b2b_idle", 64'(ready), 64'(1));
        ref_rdata = 32'hDEADBEEF;

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(1, 3))
                1:       begin r = 1'b1; w = 1'b0; end
                2:       begin r = 1'b0; w = 1'b1; end
                default: begin r = 1'b1; w = 1'b1; end
            endcase
            if ($urandom_range(0, 9) < 7)
                a = 32'(BASE) + 32'($urandom_range(0, 63) * 4) + 32'($urandom_range(0, 3));
            else
                a = $urandom;
            wd   = $urandom;
            lo   = lo_of(a);
            drop = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2 * W + 2)) : 0;
            if (w) do_access(r, w, a, wd, lo, ref_rdata, drop);
            else   do_access(r, w, a, wd, lo, {ref_mem[lo + 1], ref_mem[lo]}, drop);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
